i2s_tx: RTL and testbench

I2S_TX -- requirements
Module: i2s_tx

---
 rtl/opl2_pkg.sv | 10 +
 rtl/i2s_clk_gen.sv | 53 +++++
 rtl/i2s_tx.sv | 113 +++++++++++
 tb/tb_i2s_tx.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/opl2_pkg.sv
// Shared constants and types for the OPL2 audio path: DAC sample width and I2S framing defaults.
package opl2_pkg;

  localparam int unsigned DAC_OUTPUT_WIDTH = 16;
  localparam int unsigned I2S_SCLK_DIV     = 4;
  localparam int unsigned I2S_SLOT_WIDTH   = 32;

  typedef logic [DAC_OUTPUT_WIDTH-1:0] dac_sample_t;

endpackage

// File: rtl/i2s_clk_gen.sv
// I2S bit-clock generator: divides clk into sclk and tracks the bit position within a stereo frame.
module i2s_clk_gen
  import opl2_pkg::*;
#(
  parameter int unsigned SCLK_DIV   = I2S_SCLK_DIV,
  parameter int unsigned SLOT_WIDTH = I2S_SLOT_WIDTH,
  localparam int unsigned P_W       = $clog2(2 * SLOT_WIDTH)
) (
  input  logic           clk,
  input  logic           reset_n,
  output logic           sclk,
  output logic           falling_edge_c,
  output logic           frame_load_c,
  output logic [P_W-1:0] p
);

  localparam int unsigned FRAME_BITS = 2 * SLOT_WIDTH;
  localparam int unsigned DIV_W      = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [P_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic             sclk_q, sclk_d;
  logic             div_wrap_c;

  // A falling edge is the cycle whose clock edge registers sclk 1->0.
  always_comb begin
    div_wrap_c     = (div_cnt_q == DIV_W'(SCLK_DIV - 1));
    falling_edge_c = div_wrap_c && sclk_q;
    frame_load_c   = falling_edge_c && (bit_cnt_q == P_W'(FRAME_BITS - 1));
    div_cnt_d      = div_wrap_c ? '0 : div_cnt_q + DIV_W'(1);
    sclk_d         = div_wrap_c ? ~sclk_q : sclk_q;
    bit_cnt_d      = bit_cnt_q;
    if (falling_edge_c) begin
      bit_cnt_d = frame_load_c ? '0 : bit_cnt_q + P_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_q <= '0;
      bit_cnt_q <= P_W'(FRAME_BITS - 1);
      sclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      sclk_q    <= sclk_d;
    end
  end

  assign sclk = sclk_q;
  assign p    = bit_cnt_q;

endmodule

// File: rtl/i2s_tx.sv
// Mono-to-stereo I2S transmitter: buffers one pending DAC sample and serialises it into both slots.
module i2s_tx
  import opl2_pkg::*;
#(
  parameter int unsigned SCLK_DIV   = I2S_SCLK_DIV,
  parameter int unsigned SLOT_WIDTH = I2S_SLOT_WIDTH
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               sample_valid,
  input  logic signed [DAC_OUTPUT_WIDTH-1:0] sample,
  output logic                               i2s_sclk,
  output logic                               i2s_lrclk,
  output logic                               i2s_sd,
  output logic                               underrun,
  output logic                               overrun
);

  localparam int unsigned DW         = DAC_OUTPUT_WIDTH;
  localparam int unsigned FRAME_BITS = 2 * SLOT_WIDTH;
  localparam int unsigned P_W        = $clog2(FRAME_BITS);

  logic           falling_edge_c, frame_load_c;
  logic [P_W-1:0] p;

  i2s_clk_gen #(
    .SCLK_DIV   (SCLK_DIV),
    .SLOT_WIDTH (SLOT_WIDTH)
  ) u_clk_gen (
    .clk            (clk),
    .reset_n        (reset_n),
    .sclk           (i2s_sclk),
    .falling_edge_c (falling_edge_c),
    .frame_load_c   (frame_load_c),
    .p              (p)
  );

  logic [FRAME_BITS-1:0] shift_q, shift_d;
  dac_sample_t           active_q, active_d;
  dac_sample_t           pending_q, pending_d;
  logic                  pending_flag_q, pending_flag_d;
  logic                  sd_q, sd_d;
  logic                  lrclk_q, lrclk_d;
  logic                  underrun_q, underrun_d;
  logic                  overrun_q, overrun_d;

  // Sample left-justified in its slot, duplicated into left and right.
  function automatic logic [FRAME_BITS-1:0] frame_word(input dac_sample_t s);
    logic [SLOT_WIDTH-1:0] slot;
    slot = SLOT_WIDTH'(s) << (SLOT_WIDTH - DW);
    return {slot, slot};
  endfunction

  always_comb begin
    shift_d        = shift_q;
    active_d       = active_q;
    pending_d      = pending_q;
    pending_flag_d = pending_flag_q;
    sd_d           = sd_q;
    lrclk_d        = lrclk_q;
    underrun_d     = 1'b0;
    overrun_d      = sample_valid && pending_flag_q;

    // A sample arriving on the load cycle bypasses pending and wins over it.
    if (frame_load_c) begin
      if (sample_valid) begin
        active_d = sample;
      end else if (pending_flag_q) begin
        active_d = pending_q;
      end else begin
        underrun_d = 1'b1;
      end
      pending_flag_d = 1'b0;
    end else if (sample_valid) begin
      pending_d      = sample;
      pending_flag_d = 1'b1;
    end

    if (falling_edge_c) begin
      sd_d    = shift_q[FRAME_BITS-1];
      lrclk_d = (p == P_W'(FRAME_BITS - 1)) ? 1'b0 : (p >= P_W'(SLOT_WIDTH - 1));
      shift_d = frame_load_c ? frame_word(active_d) : {shift_q[FRAME_BITS-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q        <= '0;
      active_q       <= '0;
      pending_q      <= '0;
      pending_flag_q <= 1'b0;
      sd_q           <= 1'b0;
      lrclk_q        <= 1'b0;
      underrun_q     <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      shift_q        <= shift_d;
      active_q       <= active_d;
      pending_q      <= pending_d;
      pending_flag_q <= pending_flag_d;
      sd_q           <= sd_d;
      lrclk_q        <= lrclk_d;
      underrun_q     <= underrun_d;
      overrun_q      <= overrun_d;
    end
  end

  assign i2s_sd    = sd_q;
  assign i2s_lrclk = lrclk_q;
  assign underrun  = underrun_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: frame-window vector table, reset corner cases and a decoded random sample stream.
module tb_i2s_tx;
  import opl2_pkg::*;

  localparam int unsigned SCLK_DIV   = 2;
  localparam int unsigned SLOT_WIDTH = 32;
  localparam int unsigned DW         = DAC_OUTPUT_WIDTH;
  localparam int          SCLK_CLK   = 2 * SCLK_DIV;
  localparam int          FRAME_CLK  = SCLK_CLK * 2 * SLOT_WIDTH;
  localparam int          FIRST_LOAD = SCLK_CLK;
  localparam int          N_RAND     = 250;
  localparam int          N_VEC      = 9;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          sample_valid;
  logic [DW-1:0] sample;
  logic          i2s_sclk, i2s_lrclk, i2s_sd, underrun, overrun;

  i2s_tx #(
    .SCLK_DIV   (SCLK_DIV),
    .SLOT_WIDTH (SLOT_WIDTH)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_valid (sample_valid),
    .sample       (sample),
    .i2s_sclk     (i2s_sclk),
    .i2s_lrclk    (i2s_lrclk),
    .i2s_sd       (i2s_sd),
    .underrun     (underrun),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;
  int und_cnt = 0;
  int ovr_cnt = 0;

  typedef struct {
    logic [DW-1:0] s;
    int            frame;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    int            n_mid;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    bit            at_load;
    logic [DW-1:0] c;
    logic [DW-1:0] exp_s;
    int            exp_und;
    int            exp_ovr;
  } vec_t;
  vec_t vecs[N_VEC];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Clock cycles since the last reset release; frame load k lands on edge lload(k).
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  function automatic int lload(input int k);
    return FIRST_LOAD + FRAME_CLK * k;
  endfunction

  initial forever begin
    @(negedge clk);
    if (reset_n === 1'b1) begin
      if (underrun) und_cnt++;
      if (overrun)  ovr_cnt++;
    end
  end

  task automatic frame_done(input int f, input logic [SLOT_WIDTH-1:0] l,
                            input logic [SLOT_WIDTH-1:0] r);
    exp_t e;
    check("slot_mirror", 64'(r), 64'(l));
    check("slot_pad", 64'(l[SLOT_WIDTH-DW-1:0]), 64'(0));
    while (exp_q.size() > 0 && exp_q[0].frame < f) begin
      e = exp_q.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL sb_missed: frame %0d never decoded, expected sample %0h", e.frame, e.s);
    end
    if (exp_q.size() > 0 && exp_q[0].frame == f) begin
      e = exp_q.pop_front();
      check($sformatf("frame_sample[%0d]", f), 64'(l[SLOT_WIDTH-1 -: DW]), 64'(e.s));
    end
  endtask

  // Protocol decoder: samples sd on sclk rising edges; an lrclk change marks the final bit of a slot.
  logic [SLOT_WIDTH-1:0] slot_bits = '0;
  logic [SLOT_WIDTH-1:0] left_word = '0;
  logic [SLOT_WIDTH-1:0] word;
  logic                  prev_lr   = 1'b0;
  int                    dec_frame = 0;

  initial forever begin
    @(posedge i2s_sclk or negedge reset_n);
    if (reset_n !== 1'b1) begin
      slot_bits = '0;
      left_word = '0;
      prev_lr   = 1'b0;
      dec_frame = 0;
    end else begin
      word = {slot_bits[SLOT_WIDTH-2:0], i2s_sd};
      if (i2s_lrclk != prev_lr) begin
        if (!prev_lr) left_word = word;
        else          frame_done(dec_frame, left_word, word);
        if (!i2s_lrclk) dec_frame++;
        slot_bits = '0;
      end else begin
        slot_bits = word;
      end
      prev_lr = i2s_lrclk;
    end
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_at(input int t, input logic [DW-1:0] v);
    wait_cyc(t);
    sample       = v;
    sample_valid = 1'b1;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_sclk"},     64'(i2s_sclk),  64'(0));
    check({tag, "_lrclk"},    64'(i2s_lrclk), 64'(0));
    check({tag, "_sd"},       64'(i2s_sd),    64'(0));
    check({tag, "_underrun"}, 64'(underrun),  64'(0));
    check({tag, "_overrun"},  64'(overrun),   64'(0));
  endtask

  initial begin
    int u0, o0, k;
    logic [DW-1:0] v;

    //          n_mid  a        b        at_load c        exp_s    und ovr
    vecs[0] = '{1, 16'h8001, 16'h0000, 1'b0, 16'h0000, 16'h8001, 0, 0};
    vecs[1] = '{0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h8001, 1, 0};
    vecs[2] = '{0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h8001, 1, 0};
    vecs[3] = '{2, 16'h1234, 16'hABCD, 1'b0, 16'h0000, 16'hABCD, 0, 1};
    vecs[4] = '{0, 16'h0000, 16'h0000, 1'b1, 16'h7FFF, 16'h7FFF, 0, 0};
    vecs[5] = '{0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h7FFF, 1, 0};
    vecs[6] = '{1, 16'h5555, 16'h0000, 1'b1, 16'h00FF, 16'h00FF, 0, 1};
    vecs[7] = '{1, 16'hFFFF, 16'h0000, 1'b0, 16'h0000, 16'hFFFF, 0, 0};
    vecs[8] = '{2, 16'h0001, 16'h8000, 1'b0, 16'h0000, 16'h8000, 0, 1};

    reset_n      = 1'b0;
    sample_valid = 1'b0;
    sample       = '0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");

    reset_n = 1'b1;
    exp_q.push_back('{16'h0000, 0});
    wait_cyc(FIRST_LOAD);
    check("first_load_underrun", 64'(underrun), 64'(1));

    // Window k runs from just after load k through load k+1; its samples land in frame k+1.
    for (int r = 0; r < N_VEC; r++) begin
      wait_cyc(lload(r) + 1);
      u0 = und_cnt;
      o0 = ovr_cnt;
      if (vecs[r].n_mid >= 1) drive_at(lload(r) + 20, vecs[r].a);
      if (vecs[r].n_mid >= 2) drive_at(lload(r) + 60, vecs[r].b);
      if (vecs[r].at_load)    drive_at(lload(r + 1) - 1, vecs[r].c);
      exp_q.push_back('{vecs[r].exp_s, r + 1});
      wait_cyc(lload(r + 1) + 1);
      check($sformatf("vec%0d_underrun", r), 64'(und_cnt - u0), 64'(vecs[r].exp_und));
      check($sformatf("vec%0d_overrun", r),  64'(ovr_cnt - o0), 64'(vecs[r].exp_ovr));
    end

    // Reset in the right slot at p=40: everything clears at once and framing restarts.
    wait_cyc(lload(N_VEC + 1) + 40 * SCLK_CLK);
    check("sb_drained_before_reset", 64'(exp_q.size()), 64'(0));
    check("lrclk_at_p40", 64'(i2s_lrclk), 64'(1));
    #2;
    reset_n = 1'b0;
    #1;
    check_outputs_zero("midframe_reset");
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    exp_q.push_back('{16'h0000, 0});
    wait_cyc(FIRST_LOAD);
    check("reload_underrun", 64'(underrun), 64'(1));
    wait_cyc(FIRST_LOAD + SLOT_WIDTH * SCLK_CLK - 1);
    check("lrclk_before_rise", 64'(i2s_lrclk), 64'(0));
    wait_cyc(FIRST_LOAD + SLOT_WIDTH * SCLK_CLK);
    check("lrclk_rise_32_sclk", 64'(i2s_lrclk), 64'(1));

    // One random sample per frame: a matched rate must never flag.
    wait_cyc(lload(1) + 1);
    u0 = und_cnt;
    o0 = ovr_cnt;
    for (k = 1; k <= N_RAND; k++) begin
      v = DW'($urandom);
      drive_at(lload(k) + int'($urandom_range(8, 200)), v);
      exp_q.push_back('{v, k + 1});
      wait_cyc(lload(k + 1) + 1);
    end
    check("random_underrun", 64'(und_cnt - u0), 64'(0));
    check("random_overrun",  64'(ovr_cnt - o0), 64'(0));

    wait_cyc(lload(N_RAND + 2) + 10);
    check("sb_drained", 64'(exp_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
